hs_cdc_receiver: RTL and testbench

//  Destination end of a 4-phase req/ack CDC handshake. Lives in the clk domain.
//  - Receives an asynchronous req plus a data bus held stable by a sender in another clock domain.
//  - Returns a registered ack to that sender.
//  - Presents each captured word to a local consumer over a valid/ready interface.

---
 rtl/hs_cdc_receiver_pkg.sv | 21 ++
 rtl/hs_cdc_receiver_sync_bit.sv | 25 ++
 rtl/hs_cdc_receiver.sv | 112 +++++++++++
 tb/tb_hs_cdc_receiver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_cdc_receiver_pkg.sv
// Shared definitions for the req/ack CDC receiver: default sizes,
// FSM state encoding and the output-slot availability helper.
package hs_cdc_receiver_pkg;

    localparam int N_DEF           = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT_LO = 2'd2
    } rx_state_e;

    // The output register can take a new word if it is empty or is being
    // drained on the same edge.
    function automatic logic slot_free(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage

// File: rtl/hs_cdc_receiver_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// The chain is a pure shift register: nothing sits between the flops.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hs_cdc_receiver.sv
// Destination end of a 4-phase req/ack handshake. The synchronized request
// qualifies a one-shot sample of the sender's stable data bus. The captured
// word is handed to a local consumer through a valid/ready register. ack is
// returned straight from a flop so the sender never sees a glitch.
//
// state   | meaning
// IDLE    | ack low, waiting for a synchronized request and a free slot
// CAPTURE | word just loaded into dout, ack rises on leaving
// WAIT_LO | ack high, waiting for the sender to drop req
module hs_cdc_receiver
    import hs_cdc_receiver_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req_async,
    input  logic [N-1:0]     data_async,
    output logic             ack,
    output logic [N-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count
);

    rx_state_e        state_q, state_d;
    logic             ack_q, ack_d;
    logic [N-1:0]     dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
    logic             req_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (req_async),
        .q_o   (req_s)
    );

    // Next-state, capture and handshake decisions.
    // The word is loaded on the edge that enters CAPTURE, so a pop of the old
    // word and the load of the new one share one edge and dout_valid never
    // dips. data_async is only looked at on that edge, when req_s has been
    // high long enough for the sender's bus to be settled.
    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        xfer_count_d = xfer_count_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                ack_d = 1'b0;
                if (req_s && ena && slot_free(dout_valid_q, dout_ready)) begin
                    state_d      = ST_CAPTURE;
                    dout_d       = data_async;
                    dout_valid_d = 1'b1;
                    xfer_count_d = xfer_count_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                ack_d   = 1'b1;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, handshake and output registers; reset drops ack immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ack_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign ack        = ack_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign xfer_count = xfer_count_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_cdc_receiver.sv
// Bench for hs_cdc_receiver: a sender on an unrelated 37 ns clock with random
// phase, a scoreboard queue of words the consumer must see in order, and a
// modulo counter model for xfer_count.
`timescale 1ns/1ps
module tb_hs_cdc_receiver;

    localparam int N        = 8;
    localparam int CNT_W    = 8;
    localparam int SYNC     = 2;
    localparam int LAT_RISE = SYNC + 2;
    localparam int LAT_FALL = SYNC + 1;

    logic             clk = 1'b0;
    logic             sclk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             req_async;
    logic [N-1:0]     data_async;
    logic             dout_ready;
    logic             ack;
    logic [N-1:0]     dout;
    logic             dout_valid;
    logic             busy;
    logic [CNT_W-1:0] xfer_count;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [N-1:0]     exp_q[$];
    int               model_cnt = 0;
    realtime          sphase;

    hs_cdc_receiver #(
        .N           (N),
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_async  (req_async),
        .data_async (data_async),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Sender clock: 37 ns, random phase with a fractional offset so its edges
    // never coincide with clk edges.
    initial begin
        sphase = real'($urandom_range(0, 36)) + 0.25;
        #(sphase);
        forever begin
            sclk = ~sclk;
            #18.5;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ack(input logic val, input int bound, input bit rand_rdy, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (ack !== val && rand_rdy) begin
                #1 dout_ready = 1'($urandom_range(0, 1));
            end
        end while (ack !== val && n < bound);
        if (ack !== val) check_eq("ack_timeout", ack, val);
    endtask

    task automatic raise_req(input logic [N-1:0] d);
        @(posedge sclk);
        data_async = d;
        req_async  = 1'b1;
        exp_q.push_back(d);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic drop_req();
        @(posedge sclk);
        req_async = 1'b0;
    endtask

    task automatic xfer(input logic [N-1:0] d, input bit chk_lat, input bit rand_rdy);
        int n;
        raise_req(d);
        wait_ack(1'b1, 400, rand_rdy, n);
        if (chk_lat) check_eq("lat_rise", n, LAT_RISE);
        check_eq("xfer_count", xfer_count, model_cnt);
        drop_req();
        wait_ack(1'b0, 400, rand_rdy, n);
        if (chk_lat) check_eq("lat_fall", n, LAT_FALL);
    endtask

    // ack edges must follow the sender's req level.
    initial begin
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(posedge clk);
            #0.5;
            if (rst_n) begin
                if (ack && !prev_ack) check_eq("ack_rise_req", req_async, 1);
                if (!ack && prev_ack) check_eq("ack_fall_req", req_async, 0);
            end
            prev_ack = ack;
        end
    end

    // Consumer side: every accepted word must be the next one sent.
    initial begin
        logic [N-1:0] w;
        forever begin
            @(negedge clk);
            if (rst_n && dout_valid && dout_ready) begin
                check_eq("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check_eq("dout_order", dout, w);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [N-1:0] base;
        rst_n      = 1'b0;
        ena        = 1'b1;
        req_async  = 1'b0;
        data_async = '0;
        dout_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", ack, 0);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_valid", dout_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", xfer_count, 0);
        #2 rst_n = 1'b1;

        // 1: single transfer with exact latencies, word left pending.
        xfer(8'hA5, 1'b1, 1'b0);
        check_eq("t1_dout", dout, 8'hA5);
        check_eq("t1_valid", dout_valid, 1);

        // 2: backpressure, then drain and capture on the same edge.
        raise_req(8'h3C);
        repeat (12) begin
            @(posedge clk);
            #1;
            check_eq("bp_ack", ack, 0);
        end
        check_eq("bp_dout", dout, 8'hA5);
        check_eq("bp_busy", busy, 0);
        #1 dout_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("swap_dout", dout, 8'h3C);
        check_eq("swap_valid", dout_valid, 1);
        check_eq("swap_ack", ack, 0);
        check_eq("swap_busy", busy, 1);
        @(posedge clk);
        #1;
        check_eq("swap_ack_next", ack, 1);
        check_eq("swap_count", xfer_count, model_cnt);
        drop_req();
        wait_ack(1'b0, 50, 1'b0, n);
        check_eq("swap_lat_fall", n, LAT_FALL);

        // 3: ena gating, and a handshake that finishes with ena low.
        ena = 1'b0;
        raise_req(N'($urandom));
        repeat (10) begin
            @(posedge clk);
            #1;
            check_eq("ena_ack", ack, 0);
            check_eq("ena_busy", busy, 0);
        end
        #1 ena = 1'b1;
        wait_ack(1'b1, 50, 1'b0, n);
        check_eq("ena_lat", n, 2);
        check_eq("ena_count", xfer_count, model_cnt);
        ena = 1'b0;
        drop_req();
        wait_ack(1'b0, 50, 1'b0, n);
        check_eq("ena_lat_fall", n, LAT_FALL);
        check_eq("ena_busy_end", busy, 0);
        ena = 1'b1;

        // 4: asynchronous reset while ack is high and a word is pending.
        dout_ready = 1'b0;
        raise_req(N'($urandom));
        wait_ack(1'b1, 50, 1'b0, n);
        #2 rst_n = 1'b0;
        #0.1;
        check_eq("arst_ack", ack, 0);
        check_eq("arst_valid", dout_valid, 0);
        check_eq("arst_count", xfer_count, 0);
        check_eq("arst_busy", busy, 0);
        exp_q.delete();
        model_cnt = 0;
        req_async = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        dout_ready = 1'b1;
        xfer(N'($urandom), 1'b1, 1'b0);

        // 5: 256 back-to-back incrementing words; the counter wraps.
        base = N'($urandom);
        for (int i = 0; i < 256; i++) begin
            xfer(base + N'(i), 1'b1, 1'b0);
        end

        // 6: random words against a randomly stalling consumer.
        for (int i = 0; i < 40; i++) begin
            xfer(N'($urandom), 1'b0, 1'b1);
        end
        #1 dout_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_valid", dout_valid, 0);
        check_eq("final_count", xfer_count, model_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
